// File: rtl/zc_pkg.sv
// Shared constants for the zero-crossing period controller.
package zc_pkg;

  // Default parameter values
  localparam int unsigned CNT_W_DEF          = 24;
  localparam int unsigned THRESH_DEFAULT_DEF = 50;
  localparam int unsigned MIN_PERIOD_DEF     = 20;
  localparam int unsigned MAX_PERIOD_DEF     = 1000;
  localparam int unsigned LOCK_COUNT_DEF     = 4;

  // Sequencer states
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_ARM     = 2'd1;
  localparam logic [STATE_W-1:0] ST_MEASURE = 2'd2;
  localparam logic [STATE_W-1:0] ST_LOCKED  = 2'd3;

endpackage

// File: rtl/hyst_cmp.sv
// Registered signed hysteresis comparator with rising-edge detect.
module hyst_cmp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              valid_i,
  input  logic [DATA_W-2:0] thresh_i,
  input  logic              run_i,
  output logic              square_o,
  output logic              rise_o,
  output logic              rise_c
);

  // One extra bit so that -thresh and the sample never overflow
  localparam int unsigned CMP_W = DATA_W + 1;

  logic signed [CMP_W-1:0] sample_ext;
  logic signed [CMP_W-1:0] pos_th;
  logic signed [CMP_W-1:0] neg_th;
  logic                    square_d;

  // Compare the sample against the symmetric threshold band
  always_comb begin
    sample_ext = {sample_i[DATA_W-1], sample_i};
    pos_th     = {2'b00, thresh_i};
    neg_th     = -pos_th;
    square_d   = square_o;
    if (valid_i && run_i) begin
      if (sample_ext > pos_th) begin
        square_d = 1'b1;
      end else if (sample_ext < neg_th) begin
        square_d = 1'b0;
      end
    end
    rise_c = square_d & ~square_o;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      square_o <= 1'b0;
      rise_o   <= 1'b0;
    end else begin
      square_o <= square_d;
      rise_o   <= rise_c;
    end
  end

endmodule

// File: rtl/zc_period_ctrl.sv
// Zero-crossing sequencer: hysteresis square wave, period measurement,
// glitch/timeout rejection and lock reporting.
module zc_period_ctrl
  import zc_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned THRESH_DEFAULT = THRESH_DEFAULT_DEF,
  parameter int unsigned MIN_PERIOD     = MIN_PERIOD_DEF,
  parameter int unsigned MAX_PERIOD     = MAX_PERIOD_DEF,
  parameter int unsigned LOCK_COUNT     = LOCK_COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-2:0] thresh_in,
  input  logic              thresh_load,
  output logic              square_out,
  output logic              edge_rise,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_valid,
  output logic              locked,
  output logic              timeout
);

  localparam int unsigned CONSEC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [DATA_W-2:0]   THRESH_RST = (DATA_W-1)'(THRESH_DEFAULT);
  localparam logic [CNT_W-1:0]    MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]    MAX_P      = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]    MAX_P_M1   = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CONSEC_W-1:0] LOCK_N     = CONSEC_W'(LOCK_COUNT);

  logic [STATE_W-1:0]  state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                pv_q,     pv_d;
  logic                locked_q, locked_d;
  logic                to_q,     to_d;
  logic [DATA_W-2:0]   thresh_q;

  logic                run_c;
  logic                samp_c;
  logic                cmp_rise_c;
  logic [CNT_W-1:0]    period_p;
  logic [CONSEC_W-1:0] consec_inc;

  // Comparator runs whenever the sequencer is active
  always_comb begin
    run_c  = enable && (state_q != ST_IDLE);
    samp_c = sample_valid && run_c;
  end

  hyst_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (sample_in),
    .valid_i  (sample_valid),
    .thresh_i (thresh_q),
    .run_i    (run_c),
    .square_o (square_out),
    .rise_o   (edge_rise),
    .rise_c   (cmp_rise_c)
  );

  // Threshold register; a load takes effect from the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= THRESH_RST;
    end else if (thresh_load) begin
      thresh_q <= thresh_in;
    end
  end

  // Next-state, period counter and lock tracking
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consec_d   = consec_q;
    period_d   = period_q;
    locked_d   = locked_q;
    pv_d       = 1'b0;
    to_d       = 1'b0;
    period_p   = cnt_q + CNT_W'(1);
    consec_inc = (consec_q >= LOCK_N) ? consec_q : consec_q + CONSEC_W'(1);

    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      consec_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d    = '0;
          consec_d = '0;
          locked_d = 1'b0;
          state_d  = ST_ARM;
        end
        ST_ARM: begin
          if (samp_c && cmp_rise_c) begin
            cnt_d   = '0;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (samp_c) begin
            if (cmp_rise_c && (period_p >= MIN_P) && (period_p <= MAX_P)) begin
              period_d = period_p;
              pv_d     = 1'b1;
              cnt_d    = '0;
              consec_d = consec_inc;
              if (consec_inc >= LOCK_N) begin
                locked_d = 1'b1;
                state_d  = ST_LOCKED;
              end
            end else if (cmp_rise_c && (period_p < MIN_P)) begin
              // Glitch: edge is ignored for measurement, counting continues
              cnt_d    = period_p;
              consec_d = '0;
              locked_d = 1'b0;
              state_d  = ST_MEASURE;
            end else if (cnt_q >= MAX_P_M1) begin
              to_d     = 1'b1;
              cnt_d    = '0;
              consec_d = '0;
              locked_d = 1'b0;
              state_d  = ST_ARM;
            end else begin
              cnt_d = period_p;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      consec_q <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      to_q     <= to_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_zc_period_ctrl.sv
// Bench for zc_period_ctrl: sample-index reference model plus directed sequences.
module tb_zc_period_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 24;
  localparam longint MIN_P  = 20;
  localparam longint MAX_P  = 1000;
  localparam longint LOCK_N = 4;
  localparam longint TH_DEF = 50;
  localparam longint HI = 1000;
  localparam longint LO = -1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-2:0] thresh_in = '0;
  logic              thresh_load = 1'b0;
  logic              square_out;
  logic              edge_rise;
  logic [CNT_W-1:0]  period_out;
  logic              period_valid;
  logic              locked;
  logic              timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zc_period_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .thresh_in    (thresh_in),
    .thresh_load  (thresh_load),
    .square_out   (square_out),
    .edge_rise    (edge_rise),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks sample indices since the last accepted edge
  longint m_th = TH_DEF;
  bit     m_sq = 1'b0;
  bit     m_idle = 1'b1;
  bit     m_meas = 1'b0;
  longint m_idx = 0;
  longint m_last = 0;
  longint m_streak = 0;
  bit     m_locked = 1'b0;
  bit     e_rise = 1'b0;
  bit     e_pv = 1'b0;
  bit     e_to = 1'b0;
  longint e_period = 0;
  longint s_val;
  longint p_val;
  bit     nsq;
  bit     is_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_th = TH_DEF; m_sq = 1'b0; m_idle = 1'b1; m_meas = 1'b0;
      m_idx = 0; m_last = 0; m_streak = 0; m_locked = 1'b0;
      e_rise = 1'b0; e_pv = 1'b0; e_to = 1'b0; e_period = 0;
    end else begin
      e_rise = 1'b0; e_pv = 1'b0; e_to = 1'b0;
      if (!enable) begin
        m_idle = 1'b1; m_streak = 0; m_locked = 1'b0;
      end else if (m_idle) begin
        m_idle = 1'b0; m_meas = 1'b0;
      end else if (sample_valid) begin
        s_val = longint'(signed'(sample_in));
        nsq = (s_val > m_th) ? 1'b1 : ((s_val < -m_th) ? 1'b0 : m_sq);
        is_edge = nsq && !m_sq;
        m_sq = nsq;
        e_rise = is_edge;
        m_idx++;
        if (!m_meas) begin
          if (is_edge) begin m_meas = 1'b1; m_last = m_idx; end
        end else begin
          p_val = m_idx - m_last;
          if (is_edge && p_val >= MIN_P && p_val <= MAX_P) begin
            e_period = p_val; e_pv = 1'b1; m_last = m_idx;
            m_streak++;
            if (m_streak >= LOCK_N) m_locked = 1'b1;
          end else if (is_edge) begin
            m_streak = 0; m_locked = 1'b0;
          end else if (p_val == MAX_P) begin
            e_to = 1'b1; m_streak = 0; m_locked = 1'b0; m_meas = 1'b0;
          end
        end
      end
      if (thresh_load) m_th = longint'(thresh_in);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_square", square_out, m_sq);
      chk("m_edge_rise", edge_rise, e_rise);
      chk("m_period_out", period_out, e_period);
      chk("m_period_valid", period_valid, e_pv);
      chk("m_locked", locked, m_locked);
      chk("m_timeout", timeout, e_to);
    end
  end

  task automatic step(input bit v, input longint s);
    sample_valid = v;
    sample_in = DATA_W'(s);
    @(negedge clk);
  endtask

  task automatic restart();
    enable = 1'b0;
    step(1'b0, 0);
    enable = 1'b1;
    step(1'b0, 0);
  endtask

  task automatic run_n(input int n, input longint s);
    for (int i = 0; i < n; i++) step(1'b1, s);
  endtask

  longint t2_s [6] = '{40, 60, 0, -40, -60, 50};
  bit     t2_sq[6] = '{0, 1, 1, 1, 0, 0};
  bit     t2_er[6] = '{0, 1, 0, 0, 0, 0};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_square", square_out, 0);
    chk("rst_edge", edge_rise, 0);
    chk("rst_period", period_out, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    restart();

    // Hysteresis band at the default threshold
    for (int i = 0; i < 6; i++) begin
      step(1'b1, t2_s[i]);
      chk("t2_square", square_out, t2_sq[i]);
      chk("t2_rise", edge_rise, t2_er[i]);
    end

    // 100-sample square wave: measure and lock
    restart();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, HI);
      chk("t3_rise", edge_rise, 1);
      chk("t3_pv", period_valid, (k >= 1) ? 1 : 0);
      if (k >= 1) chk("t3_period", period_out, 100);
      chk("t3_locked", locked, (k >= 4) ? 1 : 0);
      run_n(49, HI);
      run_n(50, LO);
    end

    // Glitch while locked, then relock
    step(1'b1, HI);
    chk("t4_pv_pre", period_valid, 1);
    chk("t4_locked_pre", locked, 1);
    run_n(4, HI);
    run_n(5, LO);
    step(1'b1, HI);
    chk("t4_glitch_rise", edge_rise, 1);
    chk("t4_glitch_pv", period_valid, 0);
    chk("t4_glitch_locked", locked, 0);
    run_n(39, HI);
    run_n(50, LO);
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, HI);
      chk("t4_pv", period_valid, 1);
      chk("t4_period", period_out, 100);
      chk("t4_locked", locked, (j == 4) ? 1 : 0);
      if (j < 4) begin
        run_n(49, HI);
        run_n(50, LO);
      end
    end

    // Timeout on 1000 samples without an edge
    run_n(999, HI);
    chk("t5_to_early", timeout, 0);
    chk("t5_locked_early", locked, 1);
    step(1'b1, HI);
    chk("t5_timeout", timeout, 1);
    chk("t5_locked", locked, 0);
    step(1'b1, HI);
    chk("t5_to_pulse", timeout, 0);
    run_n(3, LO);
    step(1'b1, HI);
    chk("t5_arm_pv", period_valid, 0);
    run_n(499, HI);
    run_n(500, LO);
    step(1'b1, HI);
    chk("t5_max_pv", period_valid, 1);
    chk("t5_max_period", period_out, 1000);
    chk("t5_max_to", timeout, 0);

    // Threshold load, disable and re-enable
    restart();
    step(1'b1, LO);
    chk("t6_low", square_out, 0);
    thresh_in = (DATA_W-1)'(200);
    thresh_load = 1'b1;
    step(1'b1, 100);
    thresh_load = 1'b0;
    chk("t6_old_thresh", square_out, 1);
    step(1'b1, -250);
    chk("t6_neg", square_out, 0);
    step(1'b1, 150);
    chk("t6_hold", square_out, 0);
    enable = 1'b0;
    step(1'b0, 0);
    chk("t6_dis_locked", locked, 0);
    chk("t6_dis_pv", period_valid, 0);
    chk("t6_dis_to", timeout, 0);
    step(1'b1, HI);
    chk("t6_idle_square", square_out, 0);
    chk("t6_idle_rise", edge_rise, 0);
    enable = 1'b1;
    step(1'b0, 0);
    step(1'b1, HI);
    chk("t6_rearm_rise", edge_rise, 1);
    chk("t6_rearm_pv", period_valid, 0);
    run_n(49, HI);
    run_n(50, LO);
    step(1'b1, HI);
    chk("t6_pv", period_valid, 1);
    chk("t6_period", period_out, 100);

    // Asynchronous reset mid-cycle restores defaults including threshold
    #2 rst_n = 1'b0;
    #1;
    chk("ar_square", square_out, 0);
    chk("ar_edge", edge_rise, 0);
    chk("ar_period", period_out, 0);
    chk("ar_pv", period_valid, 0);
    chk("ar_locked", locked, 0);
    chk("ar_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0);
    step(1'b1, 51);
    chk("ar_thresh51", square_out, 1);
    step(1'b1, -51);
    chk("ar_thresh_neg51", square_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/zc_period_ctrl.md
Name: zc_period_ctrl

Overview:
Sequencer around the ADC zero-crossing hysteresis comparator. It registers signed ADC samples, applies a programmable symmetric hysteresis threshold, and produces the square wave and its rising-edge strobe. It measures the edge-to-edge period in samples, rejects glitches and timeouts, and reports lock. It sits between the ADC sample stream and downstream frequency/phase logic.

Parameters:
DATA_W, 32, signed sample width
CNT_W, 24, period counter width; must hold MAX_PERIOD
THRESH_DEFAULT, 50, threshold magnitude after reset
MIN_PERIOD, 20, shortest accepted period in samples; shorter is a glitch
MAX_PERIOD, 1000, longest accepted period in samples; longer is a timeout
LOCK_COUNT, 4, consecutive accepted periods required for lock

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
enable  in  1  run control; low forces IDLE
sample_in  in  DATA_W  signed ADC sample
sample_valid  in  1  sample strobe; one sample per high cycle
thresh_in  in  DATA_W-1  unsigned threshold magnitude
thresh_load  in  1  loads thresh_in into the threshold register
square_out  out  1  hysteresis comparator output
edge_rise  out  1  one-cycle pulse on a square_out 0->1 transition
period_out  out  CNT_W  last accepted period in samples
period_valid  out  1  one-cycle pulse when period_out updates
locked  out  1  lock status
timeout  out  1  one-cycle pulse on a missing edge

Behaviour:
- Reset values: square_out=0, edge_rise=0, period_out=0, period_valid=0, locked=0, timeout=0, thresh=THRESH_DEFAULT, cnt=0, consec=0, state=IDLE.
- Comparator: updates only on cycles with sample_valid=1.
  - sample > +thresh -> 1.
  - sample < -thresh -> 0.
  - Otherwise hold.
  - Compare at full DATA_W+1 signed width, so there is no overflow.
- Latency: sample_valid in cycle N -> square_out, edge_rise, period_valid and timeout in N+1. All outputs are registered.
- edge_rise pulses on every raw 0->1 transition in all states except IDLE.
- thresh_load applies from the next cycle. If it coincides with sample_valid, that sample uses the old threshold. Loads are accepted in every state.
- Outside IDLE, the comparator always runs. cnt counts valid samples since the last accepted edge.
- States:
  - IDLE: counters cleared, locked=0, square_out held. enable=1 -> ARM.
  - ARM: no counting, no timeout. First rising edge -> cnt=0, go to MEASURE.
  - MEASURE / LOCKED: each valid non-edge sample does cnt+1. Each edge sample evaluates P=cnt+1:
    - MIN_PERIOD<=P<=MAX_PERIOD: accepted. period_out=P, period_valid pulses, cnt=0, consec+1 (saturating). When consec reaches LOCK_COUNT: locked=1, state LOCKED.
    - P<MIN_PERIOD: glitch. No period_valid, cnt keeps counting (edge ignored for measurement), consec=0, locked=0, state MEASURE.
  - Timeout: a valid non-edge sample with cnt==MAX_PERIOD-1 (cnt would reach MAX_PERIOD) -> timeout pulse, cnt=0, consec=0, locked=0, go to ARM. An edge on that same sample is instead accepted with P=MAX_PERIOD.
- enable=0 in any state: next cycle IDLE. No period_valid or timeout pulses for in-flight samples; period_out is retained.
- Asynchronous reset mid-operation restores all reset values immediately, including thresh.
- sample_valid=0 cycles change nothing except an applied thresh_load.

Decomposition:
- Package zc_pkg holds:
  - the state enum (IDLE, ARM, MEASURE, LOCKED);
  - default constants for THRESH_DEFAULT, MIN_PERIOD, MAX_PERIOD and LOCK_COUNT;
  - the CNT_W default.
- One sub-module, hyst_cmp: registered signed hysteresis comparator.
  - Inputs: sample, valid, thresh, run.
  - Outputs: square and the rise pulse.
- The state machine, period counter and lock logic stay in zc_period_ctrl.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 at once; after release, thresh=50 (sample 51 -> square_out=1).
2. Hysteresis, thresh=50, enable=1, samples 40, 60, 0, -40, -60, 50 -> square_out 0, 1, 1, 1, 0, 0; exactly one edge_rise, in the cycle after the 60 sample.
3. Period and lock: ±1000 square wave, period 100 samples -> first edge goes to MEASURE; each later edge gives period_out=100 with period_valid; locked=1 at the 4th accepted period.
4. Glitch while locked: extra rising edge 10 samples after an edge (P=10) -> edge_rise pulses, no period_valid, locked=0; the next true edge at sample 100 gives period_out=100; lock is regained after 4 more accepted periods.
5. Timeout while locked: hold samples at +1000 -> timeout pulse on the 1000th sample after the last edge, locked=0, state ARM; with a rising edge exactly at sample 1000 instead, period_out=1000 is accepted.
6. Control edges:
   - thresh_load=200 together with sample 100 -> that sample is compared against 50.
   - A subsequent 150 holds the output.
   - enable=0 mid-MEASURE -> IDLE, locked=0, no pulses.
   - Re-enable -> ARM awaits a fresh edge.
